// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider: FSM states and the ready/start
// handshake levels used by the stall logic and the divide controller.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider: one quotient bit per cycle on operand
// magnitudes, with sign fix-up on the way into DivEnd; result = {rem, quo}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_div,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = '0;

    div_state_e          state_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    quo_q;
    logic [WIDTH-1:0]    divisor_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic [2*WIDTH-1:0]  result_q;
    logic                ready_q;

    logic [WIDTH-1:0]    dividend_mag_d;
    logic [WIDTH-1:0]    divisor_mag_d;
    logic [WIDTH:0]      shifted_d;
    logic [WIDTH:0]      diff_d;
    logic [WIDTH-1:0]    rem_d;
    logic [WIDTH-1:0]    quo_d;
    logic [WIDTH-1:0]    rem_fix_d;
    logic [WIDTH-1:0]    quo_fix_d;

    // Operand magnitudes, one restoring step, and the signed fix-up of its result.
    always_comb begin
        dividend_mag_d = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + ONE) : opdata1;
        divisor_mag_d  = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + ONE) : opdata2;
        // {rem, quo} acts as the wide partial remainder; the dividend shifts out of quo.
        shifted_d      = {rem_q, quo_q[WIDTH-1]};
        diff_d         = shifted_d - {1'b0, divisor_q};
        if (diff_d[WIDTH]) begin
            rem_d = shifted_d[WIDTH-1:0];
        end else begin
            rem_d = diff_d[WIDTH-1:0];
        end
        quo_d     = {quo_q[WIDTH-2:0], ~diff_d[WIDTH]};
        quo_fix_d = neg_quo_q ? (~quo_d + ONE) : quo_d;
        rem_fix_d = neg_rem_q ? (~rem_d + ONE) : rem_d;
    end

    // Divider FSM with registered result and ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else if (annul) begin
            state_q <= DivFree;
            ready_q <= DivResultNotReady;
        end else begin
            case (state_q)
                DivFree: begin
                    ready_q <= DivResultNotReady;
                    if (start_div == DivStart) begin
                        if (opdata2 == ZERO) begin
                            state_q <= DivByZero;
                        end else begin
                            state_q   <= DivOn;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            quo_q     <= dividend_mag_d;
                            divisor_q <= divisor_mag_d;
                            neg_quo_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            neg_rem_q <= signed_div & opdata1[WIDTH-1];
                        end
                    end else begin
                        state_q <= DivFree;
                    end
                end
                DivByZero: begin
                    state_q  <= DivEnd;
                    result_q <= '0;
                    ready_q  <= DivResultReady;
                end
                DivOn: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= DivEnd;
                        result_q <= {rem_fix_d, quo_fix_d};
                        ready_q  <= DivResultReady;
                    end else begin
                        state_q <= DivOn;
                    end
                end
                DivEnd: begin
                    state_q <= DivFree;
                    ready_q <= DivResultNotReady;
                end
                default: begin
                    state_q <= DivFree;
                    ready_q <= DivResultNotReady;
                end
            endcase
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed cases plus random divides against an
// integer-arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_div;
    logic        signed_div;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;

    int passed = 0;
    int total  = 0;
    logic [63:0] last_res;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_div  (start_div),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating division on 64-bit integers; divide-by-zero gives all-zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one divide from IDLE, scramble operands mid-flight, check latency,
    // result and one-cycle pulse. Called #1 after a rising edge.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input string tag);
        int n;
        start_div  = 1'b1;
        signed_div = s;
        opdata1    = a;
        opdata2    = b;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                signed_div = $urandom_range(0, 1);
                opdata1    = $urandom;
                opdata2    = $urandom;
            end
        end while (!ready && n < 100);
        start_div = 1'b0;
        check({tag, "_latency"}, 64'(n), (b == 32'd0) ? 64'd2 : 64'd33);
        check({tag, "_result"}, result, exp);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {63'd0, ready}, 64'd0);
        check({tag, "_hold"}, result, exp);
        last_res = exp;
    endtask

    initial begin
        int n, p1, p2;
        logic [63:0] r1, r2;
        logic [31:0] a, b;
        logic s;
        int sawready;

        rst = 1'b1; start_div = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opdata1 = 32'd0; opdata2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 64'd0);
        check("reset_ready", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "u100_7");
        do_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "s_m7_2");
        do_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, "s_7_m2");
        do_div(32'd5, 32'd0, 1'b0, 64'd0, "div_zero");
        do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, "overflow");
        do_div(32'd9, 32'd4, 1'b0, 64'h00000001_00000002, "u9_4");

        // Annul mid-divide: no pulse, result unchanged.
        start_div = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        sawready = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ready) sawready++;
            if (i == 5) begin opdata1 = 32'd77; opdata2 = 32'd5; end
        end
        annul = 1'b1; start_div = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) sawready++;
        end
        check("annul_no_pulse", 64'(sawready), 64'd0);
        check("annul_result_kept", result, last_res);
        do_div(32'd1000, 32'd3, 1'b0, 64'h00000001_0000014D, "restart_1000_3");

        // Reset mid-RUN.
        start_div = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        repeat (15) @(posedge clk);
        #1;
        start_div = 1'b0;
        rst = 1'b1;
        #1;
        check("midrun_rst_result", result, 64'd0);
        check("midrun_rst_ready", {63'd0, ready}, 64'd0);

        // Back-to-back divides with start held high out of reset.
        start_div = 1'b1; opdata1 = 32'd9; opdata2 = 32'd3;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0; p1 = 0; p2 = 0; r1 = '0; r2 = '0;
        while (p2 == 0 && n < 120) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin opdata1 = 32'd10; opdata2 = 32'd4; end
            if (ready) begin
                if (p1 == 0) begin p1 = n; r1 = result; end
                else begin p2 = n; r2 = result; start_div = 1'b0; end
            end
        end
        start_div = 1'b0;
        check("b2b_first_latency", 64'(p1), 64'd33);
        check("b2b_first_result", r1, 64'h00000000_00000003);
        check("b2b_gap", 64'(p2 - p1), 64'd34);
        check("b2b_second_result", r2, 64'h00000002_00000002);
        @(posedge clk); #1;
        check("b2b_pulse_end", {63'd0, ready}, 64'd0);

        // Random divides against the reference model.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = (i == 6) ? 32'd0 : 32'hFFFFFFFF - $urandom_range(0, 15);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = $urandom_range(0, 1);
            do_div(a, b, s, ref_div(a, b, s), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
